// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg: shared widths and state encoding for the vote count/readout blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vote_pkg;

  localparam int DEFAULT_COUNT_W = 8;
  localparam int NUM_CAND        = 4;
  localparam int CAND_ID_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vote_max_tracker.sv
// ---------------------------------------------------------------------------
// vote_max_tracker: running maximum / winner / tie over a sequence of counts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vote_max_tracker
  import vote_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 update,
  input  logic [CAND_ID_W-1:0] id,
  input  logic [COUNT_W-1:0]   count,
  output logic [CAND_ID_W-1:0] result_id,
  output logic [COUNT_W-1:0]   result_count,
  output logic                 result_tie
);

  logic [CAND_ID_W-1:0] max_id;
  logic [COUNT_W-1:0]   max_count;
  logic                 max_tie;

  // Results include the update presented this cycle, so a caller can latch
  // the final answer on the same edge as the last record.
  always_comb begin
    result_id    = max_id;
    result_count = max_count;
    result_tie   = max_tie;
    if (update) begin
      if (init) begin
        result_id    = id;
        result_count = count;
        result_tie   = 1'b0;
      end else if (count > max_count) begin
        result_id    = id;
        result_count = count;
        result_tie   = 1'b0;
      end else if (count == max_count) begin
        result_tie   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      max_id    <= '0;
      max_count <= '0;
      max_tie   <= 1'b0;
    end else begin
      max_id    <= result_id;
      max_count <= result_count;
      max_tie   <= result_tie;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vote_result_reader.sv
// ---------------------------------------------------------------------------
// vote_result_reader: snapshots four counts, streams them, then reports winner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vote_result_reader
  import vote_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 report_req,
  input  logic [COUNT_W-1:0]   cand1_vote_recvd,
  input  logic [COUNT_W-1:0]   cand2_vote_recvd,
  input  logic [COUNT_W-1:0]   cand3_vote_recvd,
  input  logic [COUNT_W-1:0]   cand4_vote_recvd,
  output logic                 busy,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [CAND_ID_W-1:0] rec_cand_id,
  output logic [COUNT_W-1:0]   rec_count,
  output logic                 rec_last,
  output logic                 result_valid,
  output logic [CAND_ID_W-1:0] winner_id,
  output logic [COUNT_W-1:0]   winner_count,
  output logic                 tie
);

  localparam logic [CAND_ID_W-1:0] LAST_ID = CAND_ID_W'(NUM_CAND - 1);

  state_t               state;
  state_t               next_state;
  logic [CAND_ID_W-1:0] idx;
  logic [CAND_ID_W-1:0] idx_next;
  logic [COUNT_W-1:0]   snap [NUM_CAND];
  logic                 accept;
  logic                 fire;
  logic                 last_fire;

  logic [CAND_ID_W-1:0] trk_id;
  logic [COUNT_W-1:0]   trk_count;
  logic                 trk_tie;

  assign idx_next  = idx + CAND_ID_W'(1);
  assign last_fire = fire && (idx == LAST_ID);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        accept = report_req && mode;
        if (accept) next_state = SEND;
      end
      SEND: begin
        fire = rec_ready;
        if (fire && (idx == LAST_ID)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  vote_max_tracker #(
    .COUNT_W (COUNT_W)
  ) u_max (
    .clock        (clock),
    .reset        (reset),
    .init         (idx == '0),
    .update       (fire),
    .id           (idx),
    .count        (snap[idx]),
    .result_id    (trk_id),
    .result_count (trk_count),
    .result_tie   (trk_tie)
  );

  // Record outputs are loaded one step ahead so every output is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx          <= '0;
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      busy         <= 1'b0;
      rec_valid    <= 1'b0;
      rec_cand_id  <= '0;
      rec_count    <= '0;
      rec_last     <= 1'b0;
      result_valid <= 1'b0;
      winner_id    <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            snap[0]     <= cand1_vote_recvd;
            snap[1]     <= cand2_vote_recvd;
            snap[2]     <= cand3_vote_recvd;
            snap[3]     <= cand4_vote_recvd;
            idx         <= '0;
            busy        <= 1'b1;
            rec_valid   <= 1'b1;
            rec_cand_id <= '0;
            rec_count   <= cand1_vote_recvd;
            rec_last    <= 1'b0;
          end
        end
        SEND: begin
          if (last_fire) begin
            rec_valid    <= 1'b0;
            rec_last     <= 1'b0;
            result_valid <= 1'b1;
            winner_id    <= trk_id;
            winner_count <= trk_count;
            tie          <= trk_tie;
          end else if (fire) begin
            idx         <= idx_next;
            rec_cand_id <= idx_next;
            rec_count   <= snap[idx_next];
            rec_last    <= (idx_next == LAST_ID);
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          rec_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vote_result_reader.sv
// ---------------------------------------------------------------------------
// tb_vote_result_reader: directed, table-driven checks of the result reader
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vote_result_reader;

  logic       clock = 1'b0;
  logic       reset, mode, report_req, rec_ready;
  logic [7:0] c1, c2, c3, c4;
  logic       busy, rec_valid, rec_last, result_valid, tie;
  logic [1:0] rec_cand_id, winner_id;
  logic [7:0] rec_count, winner_count;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  vote_result_reader dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .report_req       (report_req),
    .cand1_vote_recvd (c1),
    .cand2_vote_recvd (c2),
    .cand3_vote_recvd (c3),
    .cand4_vote_recvd (c4),
    .busy             (busy),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .rec_cand_id      (rec_cand_id),
    .rec_count        (rec_count),
    .rec_last         (rec_last),
    .result_valid     (result_valid),
    .winner_id        (winner_id),
    .winner_count     (winner_count),
    .tie              (tie)
  );

  typedef struct {
    logic [7:0] cnt [4];
    logic [1:0] w_id;
    logic [7:0] w_cnt;
    logic       w_tie;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [7:0] a, b, c, d,
                              input logic [1:0] w, input logic [7:0] wc,
                              input logic t);
    vec_t v;
    v.cnt[0] = a; v.cnt[1] = b; v.cnt[2] = c; v.cnt[3] = d;
    v.w_id = w; v.w_cnt = wc; v.w_tie = t;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic set_counts(input vec_t v);
    c1 = v.cnt[0]; c2 = v.cnt[1]; c3 = v.cnt[2]; c4 = v.cnt[3];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},         busy, 0);
    check({tag, " rec_valid"},    rec_valid, 0);
    check({tag, " rec_cand_id"},  rec_cand_id, 0);
    check({tag, " rec_count"},    rec_count, 0);
    check({tag, " rec_last"},     rec_last, 0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " winner_id"},    winner_id, 0);
    check({tag, " winner_count"}, winner_count, 0);
    check({tag, " tie"},          tie, 0);
  endtask

  // Called in the cycle after acceptance; returns in the result_valid cycle.
  task automatic expect_report(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      check("rec_valid",   rec_valid, 1);
      check("busy",        busy, 1);
      check("rec_cand_id", rec_cand_id, i);
      check("rec_count",   rec_count, v.cnt[i]);
      check("rec_last",    rec_last, (i == 3) ? 1 : 0);
      check("early result_valid", result_valid, 0);
      tick();
    end
    check("result_valid", result_valid, 1);
    check("busy at result", busy, 1);
    check("rec_valid at result", rec_valid, 0);
    check("winner_id",    winner_id, v.w_id);
    check("winner_count", winner_count, v.w_cnt);
    check("tie",          tie, v.w_tie);
  endtask

  task automatic run_report(input vec_t v);
    set_counts(v);
    mode = 1'b1; report_req = 1'b1;
    tick();
    report_req = 1'b0;
    expect_report(v);
    tick();
    check("busy after", busy, 0);
    check("result_valid pulse", result_valid, 0);
    check("winner_id held",    winner_id, v.w_id);
    check("winner_count held", winner_count, v.w_cnt);
    check("tie held",          tie, v.w_tie);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b1; mode = 1'b0; report_req = 1'b0; rec_ready = 1'b1;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    vecs[0] = mk(8'd5,   8'd9,   8'd3,  8'd7,   2'd1, 8'd9,   1'b0);
    vecs[1] = mk(8'd4,   8'd8,   8'd8,  8'd2,   2'd1, 8'd8,   1'b1);
    vecs[2] = mk(8'd0,   8'd0,   8'd0,  8'd0,   2'd0, 8'd0,   1'b1);
    vecs[3] = mk(8'd10,  8'd3,   8'd10, 8'd10,  2'd0, 8'd10,  1'b1);
    vecs[4] = mk(8'd1,   8'd2,   8'd3,  8'd250, 2'd3, 8'd250, 1'b0);
    vecs[5] = mk(8'd255, 8'd254, 8'd0,  8'd255, 2'd0, 8'd255, 1'b1);

    tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");

    // A request in voting mode is ignored.
    mode = 1'b0; report_req = 1'b1;
    tick();
    report_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mode0 busy", busy, 0);
      check("mode0 rec_valid", rec_valid, 0);
      tick();
    end

    for (int k = 0; k < 6; k++) run_report(vecs[k]);

    // Stall record 2 for three cycles.
    v = vecs[0];
    set_counts(v);
    mode = 1'b1; report_req = 1'b1;
    tick();
    report_req = 1'b0;
    check("stall rec0", rec_count, 5);
    tick();
    check("stall rec1", rec_count, 9);
    tick();
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rec_ready = 1'b1;
      check("stall valid", rec_valid, 1);
      check("stall id",    rec_cand_id, 2);
      check("stall count", rec_count, 3);
      check("stall last",  rec_last, 0);
      check("stall no result", result_valid, 0);
      tick();
    end
    check("stall rec3 id",   rec_cand_id, 3);
    check("stall rec3 last", rec_last, 1);
    tick();
    check("stall result_valid", result_valid, 1);
    check("stall winner_id", winner_id, 1);
    check("stall winner_count", winner_count, 9);
    tick();
    check("stall busy after", busy, 0);

    // Snapshot integrity, mode toggle and request while busy.
    v = vecs[0];
    set_counts(v);
    mode = 1'b1; report_req = 1'b1;
    tick();
    report_req = 1'b0;
    c2 = 8'd200; mode = 1'b0;
    check("snap rec0", rec_count, 5);
    tick();
    check("snap rec1", rec_count, 9);
    mode = 1'b1; report_req = 1'b1;
    tick();
    report_req = 1'b0;
    check("snap rec2", rec_count, 3);
    tick();
    check("snap rec3", rec_count, 7);
    tick();
    check("snap result_valid", result_valid, 1);
    check("snap winner_count", winner_count, 9);
    check("snap winner_id", winner_id, 1);
    tick();
    check("busy req ignored busy", busy, 0);
    check("busy req ignored valid", rec_valid, 0);
    tick();
    check("busy req not queued", rec_valid, 0);

    // Back-to-back: request in DONE ignored, accepted in the next IDLE cycle.
    set_counts(vecs[4]);
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    expect_report(vecs[4]);
    report_req = 1'b1;
    set_counts(vecs[1]);
    tick();
    check("b2b idle busy", busy, 0);
    check("b2b idle valid", rec_valid, 0);
    tick();
    report_req = 1'b0;
    expect_report(vecs[1]);
    tick();

    // Reset during record 1.
    set_counts(vecs[0]);
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    tick();
    check("pre-reset rec1", rec_cand_id, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid-reset");
    for (int i = 0; i < 6; i++) begin
      check("no partial result", result_valid, 0);
      check("idle after reset", rec_valid, 0);
      tick();
    end
    run_report(vecs[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
